// File: rtl/mac_arbiter.sv
// mac_arbiter: shares one external MAC among NREQ requesters, one
// dot-product job of KLEN beats at a time, with round-robin arbitration.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req               per-requester job request
//   a_flat, b_flat    requester i operands at [i*DW +: DW]
//   gnt               one-hot grant, held from GRANT through RESP
//   beat_idx          beat the granted requester drives now
//   busy              high whenever the FSM is not idle
//   mac_clr, mac_en   accumulator clear pulse / accumulate enable
//   mac_a, mac_b      winner's operands while streaming, else 0
//   mac_out           accumulator value from the MAC
//   rsp_valid         one-cycle result strobe to the job owner
//   rsp_data          result, held until the next response
//
// Build option: MAC_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module mac_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int ACCW    = 16,
  parameter int KLEN    = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   a_flat,
  input  logic [NREQ*DW-1:0]   b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           beat_idx,
  output logic                 busy,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic [DW-1:0]        mac_a,
  output logic [DW-1:0]        mac_b,
  input  logic [ACCW-1:0]      mac_out,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [ACCW-1:0]      rsp_data
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_STREAM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [PW-1:0] win;
  logic [PW-1:0] pick;
  logic          found;

`ifndef MAC_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;
`endif

  // Winner search. Iterating downwards lets the
  // highest-priority candidate be the last to assign.
  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef MAC_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick  = PW'(i);
        found = 1'b1;
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        pick  = PW'(j);
        found = 1'b1;
      end
    end
`endif
  end

  // State register and phase counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else
        cnt <= cnt + 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (found) state_nx = S_GRANT;
      S_GRANT:
        state_nx = S_STREAM;
      S_STREAM:
        if (cnt == 4'(KLEN - 1)) state_nx = S_WAIT;
      S_WAIT:
        if (cnt == 4'(MAC_LAT - 1)) state_nx = S_RESP;
      S_RESP:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Job registers. The result is captured on the last WAIT
  // edge, so rsp_data is valid in the same cycle as rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      win       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      if (state == S_IDLE && found) begin
        win <= pick;
        gnt <= NREQ'(1) << pick;
      end
      if (state == S_WAIT && state_nx == S_RESP) begin
        rsp_data  <= mac_out;
        rsp_valid <= NREQ'(1) << win;
      end
      if (state == S_RESP) begin
        gnt <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
        if (int'(win) == NREQ - 1)
          ptr <= '0;
        else
          ptr <= win + PW'(1);
`endif
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state != S_IDLE);
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    beat_idx = '0;
    mac_a    = '0;
    mac_b    = '0;
    case (state)
      S_GRANT: mac_clr = 1'b1;
      S_STREAM: begin
        mac_en   = 1'b1;
        beat_idx = cnt;
        mac_a    = a_flat[win*DW +: DW];
        mac_b    = b_flat[win*DW +: DW];
      end
      default: ;
    endcase
  end

endmodule
